mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_pkg.sv | 14 +
 rtl/ArrayMultiplier.sv | 15 +
 rtl/mac_accumulator.sv | 108 ++++++++++
 tb/tb_mac_accumulator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate block: FSM encodings and default widths.
package mac_pkg;

  localparam int unsigned AccWDefault = 24;
  localparam int unsigned LenWDefault = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } mac_state_e;

endpackage

// File: rtl/ArrayMultiplier.sv
// Unsigned 8x8 array multiplier: shifted AND partial products summed row by row.
module ArrayMultiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] productBus
);

  always_comb begin
    productBus = '0;
    for (int i = 0; i < 8; i++) begin
      productBus = productBus + ({8'b0, a & {8{b[i]}}} << i);
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Job-based multiply-accumulate: sums a*b over len beats, then holds the result until taken.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = AccWDefault,
  parameter int unsigned LEN_W = LenWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  mac_state_e       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      p_q, p_d;
  logic             p_vld_q, p_vld_d;
  logic [15:0]      product;
  logic [ACC_W:0]   sum;
  logic             accept;

  ArrayMultiplier u_mult (
    .a          (a),
    .b          (b),
    .productBus (product)
  );

  // in_ready depends only on registered state, never on in_valid/out_ready.
  assign in_ready  = (state_q == StAccum) && (rem_q != '0);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign acc_out   = (state_q == StDone) ? acc_q : '0;
  assign overflow  = ovf_q;
  assign sum       = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, p_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    p_d     = p_q;
    p_vld_d = 1'b0;

    if (p_vld_q) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) ovf_d = 1'b1;
    end

    unique case (state_q)
      StIdle: ;
      StAccum: begin
        if (accept) begin
          p_d     = product;
          p_vld_d = 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == {{(LEN_W - 1){1'b0}}, 1'b1}) state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Job launch: from IDLE, or back-to-back with the result handshake.
    if (start && ((state_q == StIdle) || ((state_q == StDone) && out_ready))) begin
      acc_d = '0;
      ovf_d = 1'b0;
      if (len != '0) begin
        state_d = StAccum;
        rem_d   = len;
      end else begin
        state_d = StDone;
        rem_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: a 24-bit and a 16-bit accumulator share stimulus and are checked together.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, overflow, busy;
  logic [23:0] acc_out;
  logic        in_ready16, out_valid16, overflow16, busy16;
  logic [15:0] acc_out16;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow), .busy(busy)
  );

  mac_accumulator #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready16), .a(a), .b(b), .out_valid(out_valid16), .out_ready(out_ready),
    .acc_out(acc_out16), .overflow(overflow16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [7:0] av, input logic [7:0] bv);
    int cnt = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    if (cnt >= 50) chk({tag, "_ready_timeout"}, 32'(cnt), 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  // Expected values derived from the full unbounded sum for each width.
  task automatic get_result(input string tag, input longint total);
    int cnt = 0;
    while (!out_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    if (cnt >= 50) chk({tag, "_done_timeout"}, 32'(cnt), 32'd0);
    chk({tag, "_acc24"}, 32'(acc_out), 32'(total % (64'd1 << 24)));
    chk({tag, "_ovf24"}, 32'(overflow), 32'(total >= (64'd1 << 24)));
    chk({tag, "_vld16"}, 32'(out_valid16), 32'd1);
    chk({tag, "_acc16"}, 32'(acc_out16), 32'(total % 64'd65536));
    chk({tag, "_ovf16"}, 32'(overflow16), 32'(total >= 64'd65536));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Power-up reset values
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Three beats, latency to out_valid
    start_job(8'd3);
    chk("j1_busy", 32'(busy), 32'd1);
    chk("j1_in_ready", 32'(in_ready), 32'd1);
    chk("j1_acc_hidden", 32'(acc_out), 32'd0);
    beat("j1b0", 8'd10, 8'd20);
    beat("j1b1", 8'd20, 8'd20);
    beat("j1b2", 8'd20, 8'd251);
    chk("j1_drain_in_ready", 32'(in_ready), 32'd0);
    chk("j1_drain_out_valid", 32'(out_valid), 32'd0);
    chk("j1_drain_acc", 32'(acc_out), 32'd0);
    tick();
    chk("j1_out_valid_edge2", 32'(out_valid), 32'd1);
    get_result("j1", 5620);

    // Zero-length job
    start_job(8'd0);
    chk("j0_out_valid", 32'(out_valid), 32'd1);
    chk("j0_in_ready", 32'(in_ready), 32'd0);
    get_result("j0", 0);

    // Overflow on the 16-bit instance, then cleared by the next job
    start_job(8'd2);
    beat("ovb0", 8'd255, 8'd255);
    beat("ovb1", 8'd255, 8'd255);
    get_result("ov", 130050);
    start_job(8'd1);
    beat("ovc", 8'd3, 8'd4);
    get_result("ovclr", 12);

    // Stall in DONE with ignored start, then back-to-back launch
    start_job(8'd1);
    beat("hb", 8'd5, 8'd6);
    tick();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd2;
      tick();
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_acc", 32'(acc_out), 32'd30);
    end
    start = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    len = 8'd1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("b2b_vld_drop", 32'(out_valid), 32'd0);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    chk("b2b_in_ready16", 32'(in_ready16), 32'd1);
    beat("b2b", 8'd2, 8'd3);
    get_result("b2b", 6);

    // in_valid gaps: 1,0,0,1,0,1 ; invalid beats carry junk operands
    start_job(8'd3);
    for (int i = 0; i < 6; i++) begin
      in_valid = (i == 0) || (i == 3) || (i == 5);
      a = in_valid ? 8'(i + 1) : 8'd99;
      b = in_valid ? 8'(i + 2) : 8'd99;
      tick();
    end
    in_valid = 1'b0;
    get_result("gap", 2 + 20 + 42);

    // Reset mid-job
    start_job(8'd3);
    beat("rb0", 8'd10, 8'd10);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_busy16", 32'(busy16), 32'd0);
    chk("mid_rst_acc", 32'(acc_out), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("rst_held_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_job(8'd1);
    beat("post_rst", 8'd7, 8'd9);
    get_result("post_rst", 63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
